// File: rtl/dram_miss_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_miss_arbiter_pkg : shared encodings and default DRAM geometry    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dram_miss_arbiter_pkg;

  localparam int unsigned LATENCY_DEF = 20;
  localparam int unsigned BLOCK_W_DEF = 128;
  localparam int unsigned BADDR_W_DEF = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dram_miss_arbiter_latency_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | latency_counter : counts 0..LATENCY-1, flags the final access cycle   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module latency_counter #(
  parameter int LATENCY = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] count_q;

  assign last_o = (count_q == CW'(LATENCY - 1));

  // Wrapping on last keeps the count inside 0..LATENCY-1 for any LATENCY.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last_o ? '0 : count_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_miss_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_miss_arbiter : round-robin I/D miss sequencer, writeback + fill  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dram_miss_arbiter
  import dram_miss_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int BADDR_W = BADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_i,
  input  logic [BADDR_W-1:0] addr_i,
  input  logic               req_d,
  input  logic [BADDR_W-1:0] addr_d,
  input  logic               wb_d,
  input  logic [BADDR_W-1:0] wb_addr_d,
  input  logic [BLOCK_W-1:0] wb_data_d,
  input  logic [BLOCK_W-1:0] dram_rdata,
  output logic [BADDR_W-1:0] dram_addr,
  output logic               dram_we,
  output logic [BLOCK_W-1:0] dram_wdata,
  output logic [BLOCK_W-1:0] fill_data,
  output logic               done_i,
  output logic               done_d,
  output logic               stall_i,
  output logic               stall_d,
  output logic               busy
);

  state_t               state_q;
  logic                 owner_q;
  logic                 last_grant_q;
  logic [BADDR_W-1:0]   fill_addr_q;
  logic [BADDR_W-1:0]   wb_addr_q;
  logic [BLOCK_W-1:0]   wb_data_q;
  logic [BLOCK_W-1:0]   fill_data_q;

  logic w_grant_d;
  logic w_cnt_last;
  logic w_cnt_en;
  logic w_cnt_clear;

  // D wins when alone, or on a tie when I was served last.
  assign w_grant_d   = req_d && (!req_i || (last_grant_q == OWNER_I));
  assign w_cnt_en    = (state_q == WB) || (state_q == FILL);
  assign w_cnt_clear = (state_q == IDLE);

  latency_counter #(
    .LATENCY (LATENCY)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (w_cnt_clear),
    .en_i    (w_cnt_en),
    .last_o  (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_I;
      fill_addr_q  <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      fill_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i || req_d) begin
            owner_q     <= w_grant_d ? OWNER_D : OWNER_I;
            fill_addr_q <= w_grant_d ? addr_d : addr_i;
            if (w_grant_d && wb_d) begin
              wb_addr_q <= wb_addr_d;
              wb_data_q <= wb_data_d;
              state_q   <= WB;
            end else begin
              state_q   <= FILL;
            end
          end
        end
        WB: begin
          if (w_cnt_last) state_q <= FILL;
        end
        FILL: begin
          if (w_cnt_last) begin
            fill_data_q <= dram_rdata;
            state_q     <= DONE;
          end
        end
        DONE: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dram_addr  = (state_q == WB) ? wb_addr_q : fill_addr_q;
  assign dram_wdata = wb_data_q;
  assign dram_we    = (state_q == WB) && w_cnt_last;
  assign fill_data  = fill_data_q;
  assign done_i     = (state_q == DONE) && (owner_q == OWNER_I);
  assign done_d     = (state_q == DONE) && (owner_q == OWNER_D);
  assign stall_i    = req_i && !done_i;
  assign stall_d    = req_d && !done_d;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dram_miss_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dram_miss_arbiter : directed self-checking bench for the arbiter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dram_miss_arbiter;

  localparam int L  = 20;
  localparam int BW = 128;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_i, req_d, wb_d;
  logic [AW-1:0] addr_i, addr_d, wb_addr_d;
  logic [BW-1:0] wb_data_d, dram_rdata;
  logic [AW-1:0] dram_addr;
  logic          dram_we;
  logic [BW-1:0] dram_wdata, fill_data;
  logic          done_i, done_d, stall_i, stall_d, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_miss_arbiter #(.LATENCY(L), .BLOCK_W(BW), .BADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .req_d      (req_d),
    .addr_d     (addr_d),
    .wb_d       (wb_d),
    .wb_addr_d  (wb_addr_d),
    .wb_data_d  (wb_data_d),
    .dram_rdata (dram_rdata),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .fill_data  (fill_data),
    .done_i     (done_i),
    .done_d     (done_d),
    .stall_i    (stall_i),
    .stall_d    (stall_d),
    .busy       (busy)
  );

  // DRAM model: unwritten blocks return a pattern derived from the address.
  logic [BW-1:0] wmem [256];
  bit            wvld [256];

  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {14'd0, a};
    if (a == 18'h00123) return {32'h11, 32'h22, 32'h33, 32'h44};
    return {32'hC0DE0000 | w, 32'hBEEF0000 ^ w, w, ~w};
  endfunction

  always @(posedge clk) begin
    if (dram_we) begin
      wmem[dram_addr[7:0]] <= dram_wdata;
      wvld[dram_addr[7:0]] <= 1'b1;
    end
  end

  always_comb dram_rdata = wvld[dram_addr[7:0]] ? wmem[dram_addr[7:0]] : blk(dram_addr);

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until the selected done pulse, logging any DRAM writes seen.
  task automatic wait_done(input bit side_d, output int n, output int we_cnt, output int we_n,
                           output logic [AW-1:0] we_addr, output logic [BW-1:0] we_data);
    n = 0; we_cnt = 0; we_n = -1; we_addr = '0; we_data = '0;
    while (!(side_d ? done_d : done_i) && n < 200) begin
      step();
      n++;
      if (dram_we) begin
        we_cnt++;
        we_n    = n;
        we_addr = dram_addr;
        we_data = dram_wdata;
      end
    end
  endtask

  task automatic wait_any(output int n, output bit side_d);
    n = 0;
    while (!(done_i || done_d) && n < 200) begin
      step();
      n++;
    end
    side_d = done_d;
  endtask

  int            n, wc, wn, we_tot;
  bit            side;
  logic [AW-1:0] wa;
  logic [BW-1:0] wdat;
  logic [BW-1:0] pat;

  initial begin
    reset = 1'b1; req_i = 1'b0; req_d = 1'b0; wb_d = 1'b0;
    addr_i = '0; addr_d = '0; wb_addr_d = '0; wb_data_d = '0;
    req_i = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done_i", done_i, 0);
    chk("rst_done_d", done_d, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_addr", dram_addr, 0);
    chk("rst_wdata", dram_wdata, 0);
    chk("rst_fill", fill_data, 0);
    chk("rst_stall_i", stall_i, 1);
    req_i = 1'b0;
    reset = 1'b0;
    step();

    // I-only miss
    addr_i = 18'h00123; req_i = 1'b1;
    wait_done(1'b0, n, wc, wn, wa, wdat);
    chk("i_lat", n, L + 1);
    chk("i_fill", fill_data, {32'h11, 32'h22, 32'h33, 32'h44});
    chk("i_no_we", wc, 0);
    chk("i_stall_at_done", stall_i, 0);
    req_i = 1'b0;
    step();
    chk("i_done_pulse", done_i, 0);
    chk("i_idle", busy, 0);

    // D dirty miss
    wb_d = 1'b1; wb_addr_d = 18'h00040; wb_data_d = {32{4'hA}}; addr_d = 18'h00080; req_d = 1'b1;
    wait_done(1'b1, n, wc, wn, wa, wdat);
    chk("d_lat", n, 2 * L + 1);
    chk("d_we_cnt", wc, 1);
    chk("d_we_cycle", wn, L);
    chk("d_we_addr", wa, 18'h00040);
    chk("d_we_data", wdat, {32{4'hA}});
    chk("d_fill", fill_data, blk(18'h00080));
    req_d = 1'b0; wb_d = 1'b0;
    step();
    chk("d_done_pulse", done_d, 0);

    // Tie with D served last: I wins, D follows immediately
    addr_i = 18'h00010; addr_d = 18'h00020; req_i = 1'b1; req_d = 1'b1;
    wait_done(1'b0, n, wc, wn, wa, wdat);
    chk("tieI_lat", n, L + 1);
    chk("tieI_stall_d", stall_d, 1);
    req_i = 1'b0;
    wait_done(1'b1, n, wc, wn, wa, wdat);
    chk("tieI_d_lat", n, L + 2);
    chk("tieI_d_fill", fill_data, blk(18'h00020));
    req_d = 1'b0;
    step();

    // Simultaneous from reset: D first
    reset = 1'b1; step(); reset = 1'b0;
    addr_i = 18'h00011; addr_d = 18'h00022; req_i = 1'b1; req_d = 1'b1;
    wait_done(1'b1, n, wc, wn, wa, wdat);
    chk("sim_d_lat", n, L + 1);
    chk("sim_stall_i", stall_i, 1);
    chk("sim_done_i_low", done_i, 0);
    req_d = 1'b0;
    wait_done(1'b0, n, wc, wn, wa, wdat);
    chk("sim_i_lat", n, L + 2);
    chk("sim_i_fill", fill_data, blk(18'h00011));
    req_i = 1'b0;
    step();

    // Back-to-back contention: winner drops for the IDLE cycle then reissues
    req_i = 1'b1; req_d = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_any(n, side);
      chk($sformatf("b2b_side%0d", r), side, (r % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("b2b_lat%0d", r), n, (r == 0) ? L + 1 : L);
      if (side) req_d = 1'b0; else req_i = 1'b0;
      step();
      chk($sformatf("b2b_pulse%0d", r), done_i | done_d, 0);
      step();
      chk($sformatf("b2b_busy%0d", r), busy, 1);
      if (side) req_d = 1'b1; else req_i = 1'b1;
    end
    // Let the outstanding grant finish, then quiesce
    wait_any(n, side);
    req_i = 1'b0; req_d = 1'b0;
    step(); step();
    chk("b2b_quiet", busy, 0);

    // Reset mid-WB at counter = 10
    wb_d = 1'b1; wb_addr_d = 18'h00040; wb_data_d = {32{4'h5}}; addr_d = 18'h00080; req_d = 1'b1;
    we_tot = 0;
    repeat (11) begin
      step();
      if (dram_we) we_tot++;
    end
    reset = 1'b1;
    step();
    if (dram_we) we_tot++;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done_d, 0);
    chk("rmid_no_we", we_tot, 0);
    reset = 1'b0;
    wait_done(1'b1, n, wc, wn, wa, wdat);
    chk("rmid_reissue_lat", n, 2 * L + 1);
    chk("rmid_reissue_we", wc, 1);
    req_d = 1'b0; wb_d = 1'b0;
    step();

    // Same-block victim and fill
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wb_d = 1'b1; wb_addr_d = 18'h00055; addr_d = 18'h00055; wb_data_d = pat; req_d = 1'b1;
    wait_done(1'b1, n, wc, wn, wa, wdat);
    chk("same_lat", n, 2 * L + 1);
    chk("same_fill", fill_data, pat);
    req_d = 1'b0; wb_d = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
